// File: rtl/rcv_ctrl.sv
// rcv_ctrl: bus-side receive FIFO with status/control and data registers, overrun flag and irq.
module rcv_ctrl #(
   parameter int ADDR_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        wr,
   input  logic        addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        wt,
   output logic        irq,
   input  logic        rcv_full,
   input  logic [7:0]  rcv_data
);
   localparam int DEPTH = 1 << ADDR_W;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] rp, wp;
   logic [ADDR_W:0]   cnt;
   logic              ien, ovr, rdy, full_q, pop, push, overrun, ctl_wr;
   assign rdy      = cnt != '0;
   assign full_q   = cnt == (ADDR_W+1)'(DEPTH);
   assign pop      = en & ~wr & addr & rdy;
   assign push     = rcv_full & (~full_q | pop);
   assign overrun  = rcv_full & full_q & ~pop;
   assign ctl_wr   = en & wr & ~addr;
   assign irq      = ien & rdy;
   assign wt       = 1'b0;
   assign data_out = !en ? 32'd0 : addr ? {24'd0, mem[rp]} : {29'd0, ovr, ien, rdy};
   always_ff @(posedge clk)
      if (push && !reset) mem[wp] <= rcv_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
         ien <= 1'b0;
         ovr <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
         if (ctl_wr) ien <= data_in[1];
         // a same-cycle overrun beats the clearing write
         if (overrun) ovr <= 1'b1;
         else if (ctl_wr && data_in[2]) ovr <= 1'b0;
      end
   end
endmodule
